// File: rtl/hdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdu_pkg
// Description : Shared types and helpers for the hazard detection unit:
//               controller state encoding, register address width and the
//               drain/freeze counter width function.
// Revision    : 1.0 - initial release
// ============================================================================
package hdu_pkg;

    // Register-file address width used by the pipeline
    localparam int REG_ADDR_W = 3;

    // Controller state; the encoding is exported on hduState for debug
    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_MEM_BUSY  = 2'd1,
        S_INT_DRAIN = 2'd2,
        S_INT_ACK   = 2'd3
    } hdu_state_e;

    // Counter width: enough bits for max(mem_lat, int_drain) - 1, never zero
    function automatic int cnt_width(input int mem_lat, input int int_drain);
        int m;
        m = (mem_lat > int_drain) ? mem_lat : int_drain;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdu_dep_compare.sv
`default_nettype none
// ============================================================================
// Module      : hdu_dep_compare
// Description : Purely combinational dependency comparator. Flags a load-use
//               hazard (decode operand produced by a load in EX) and a
//               load-to-branch hazard (branch operand produced by a load in
//               MEM, which forwarding cannot reach because branches resolve
//               in decode).
// Revision    : 1.0 - initial release
// ============================================================================
module hdu_dep_compare
    import hdu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_src_a,
    input  logic [ADDR_W-1:0] i_src_b,
    input  logic              i_uses_src_a,
    input  logic              i_uses_src_b,
    input  logic              i_is_branch,
    input  logic [ADDR_W-1:0] i_dest_ex,
    input  logic              i_mtr_ex,
    input  logic              i_rw_ex,
    input  logic [ADDR_W-1:0] i_dest_mem,
    input  logic              i_mtr_mem,
    input  logic              i_rw_mem,
    output logic              o_load_use,
    output logic              o_br_load
);

    logic w_load_in_ex;
    logic w_load_in_mem;
    logic w_match_a_ex;
    logic w_match_b_ex;
    logic w_match_a_mem;

    // Register-address matches against the loads sitting in EX and MEM
    always_comb begin
        w_load_in_ex  = i_mtr_ex & i_rw_ex;
        w_load_in_mem = i_mtr_mem & i_rw_mem;
        w_match_a_ex  = i_uses_src_a & (i_src_a == i_dest_ex);
        w_match_b_ex  = i_uses_src_b & (i_src_b == i_dest_ex);
        w_match_a_mem = (i_src_a == i_dest_mem);
        o_load_use    = w_load_in_ex & (w_match_a_ex | w_match_b_ex);
        o_br_load     = i_is_branch & w_load_in_mem & w_match_a_mem;
    end

endmodule
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : Stall/flush controller for the 5-stage pipeline. Covers the
//               hazards forwarding cannot: load-use, load-to-branch,
//               multi-cycle MEM ops and interrupt entry (pipeline drain).
//               All controls are combinational from state and inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit #(
    parameter int REG_ADDR_W = 3,
    parameter int MEM_LAT    = 2,
    parameter int INT_DRAIN  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] srcAAfterF2D,
    input  logic [REG_ADDR_W-1:0] srcBAfterF2D,
    input  logic                  usesSrcA,
    input  logic                  usesSrcB,
    input  logic                  isBranchAfterF2D,
    input  logic                  branchTaken,
    input  logic [REG_ADDR_W-1:0] destAfterD2E,
    input  logic                  MTRAfterD2E,
    input  logic                  RWAfterD2E,
    input  logic [REG_ADDR_W-1:0] destAfterE2M,
    input  logic                  MTRAfterE2M,
    input  logic                  RWAfterE2M,
    input  logic                  memMultiAfterE2M,
    input  logic                  interruptReq,
    output logic                  stallPC,
    output logic                  stallF2D,
    output logic                  flushF2D,
    output logic                  bubbleD2E,
    output logic                  stallD2E,
    output logic                  stallE2M,
    output logic                  bubbleM2W,
    output logic                  intAck,
    output logic [1:0]            hduState
);

    import hdu_pkg::*;

    localparam int               CNT_W        = cnt_width(MEM_LAT, INT_DRAIN);
    // The trigger cycle counts as the first freeze cycle, so the counter
    // covers the remaining MEM_LAT-2 cycles (loaded as MEM_LAT-3).
    localparam logic [CNT_W-1:0] C_MEM_LOAD   = CNT_W'((MEM_LAT > 2) ? (MEM_LAT - 3) : 0);
    localparam logic [CNT_W-1:0] C_DRAIN_LOAD = CNT_W'((INT_DRAIN > 1) ? (INT_DRAIN - 1) : 0);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
    localparam logic             C_MEM_MULTI  = (MEM_LAT > 1);
    localparam logic             C_MEM_LONG   = (MEM_LAT > 2);

    hdu_state_e       r_state_q;
    hdu_state_e       w_state_d;
    logic [CNT_W-1:0] r_mem_cnt_q;
    logic [CNT_W-1:0] w_mem_cnt_d;
    logic [CNT_W-1:0] r_drain_cnt_q;
    logic [CNT_W-1:0] w_drain_cnt_d;
    logic             r_mem_done_q;
    logic             w_mem_done_d;
    // A multi-cycle freeze that started while draining; keeps INT_DRAIN as
    // the visible state while the MEM op finishes.
    logic             r_drain_frz_q;
    logic             w_drain_frz_d;

    logic w_load_use;
    logic w_br_load;
    logic w_hazard;
    logic w_mem_trig;

    logic w_stall_pc;
    logic w_stall_f2d;
    logic w_flush_f2d;
    logic w_bubble_d2e;
    logic w_stall_d2e;
    logic w_stall_e2m;
    logic w_bubble_m2w;
    logic w_int_ack;

    hdu_dep_compare #(
        .ADDR_W (REG_ADDR_W)
    ) u_dep_compare (
        .i_src_a      (srcAAfterF2D),
        .i_src_b      (srcBAfterF2D),
        .i_uses_src_a (usesSrcA),
        .i_uses_src_b (usesSrcB),
        .i_is_branch  (isBranchAfterF2D),
        .i_dest_ex    (destAfterD2E),
        .i_mtr_ex     (MTRAfterD2E),
        .i_rw_ex      (RWAfterD2E),
        .i_dest_mem   (destAfterE2M),
        .i_mtr_mem    (MTRAfterE2M),
        .i_rw_mem     (RWAfterE2M),
        .o_load_use   (w_load_use),
        .o_br_load    (w_br_load)
    );

    // Hazard qualifiers; memDone blocks a retrigger during the op's last MEM cycle
    always_comb begin
        w_hazard   = w_load_use | w_br_load;
        w_mem_trig = memMultiAfterE2M & ~r_mem_done_q & C_MEM_MULTI;
    end

    // State and counter registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q     <= S_RUN;
            r_mem_cnt_q   <= '0;
            r_drain_cnt_q <= '0;
            r_mem_done_q  <= 1'b0;
            r_drain_frz_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_mem_cnt_q   <= w_mem_cnt_d;
            r_drain_cnt_q <= w_drain_cnt_d;
            r_mem_done_q  <= w_mem_done_d;
            r_drain_frz_q <= w_drain_frz_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        w_state_d     = r_state_q;
        w_mem_cnt_d   = r_mem_cnt_q;
        w_drain_cnt_d = r_drain_cnt_q;
        w_mem_done_d  = 1'b0;
        w_drain_frz_d = r_drain_frz_q;
        case (r_state_q)
            S_RUN: begin
                if (w_mem_trig) begin
                    if (C_MEM_LONG) begin
                        w_state_d   = S_MEM_BUSY;
                        w_mem_cnt_d = C_MEM_LOAD;
                    end else begin
                        w_mem_done_d = 1'b1;
                    end
                end else if (!w_hazard && !branchTaken && interruptReq) begin
                    w_state_d     = S_INT_DRAIN;
                    w_drain_cnt_d = C_DRAIN_LOAD;
                end
            end
            S_MEM_BUSY: begin
                if (r_mem_cnt_q == '0) begin
                    w_state_d    = S_RUN;
                    w_mem_done_d = 1'b1;
                end else begin
                    w_mem_cnt_d = r_mem_cnt_q - C_CNT_ONE;
                end
            end
            S_INT_DRAIN: begin
                // Drain count is held whenever the MEM stage is frozen
                if (r_drain_frz_q) begin
                    if (r_mem_cnt_q == '0) begin
                        w_drain_frz_d = 1'b0;
                        w_mem_done_d  = 1'b1;
                    end else begin
                        w_mem_cnt_d = r_mem_cnt_q - C_CNT_ONE;
                    end
                end else if (w_mem_trig) begin
                    if (C_MEM_LONG) begin
                        w_drain_frz_d = 1'b1;
                        w_mem_cnt_d   = C_MEM_LOAD;
                    end else begin
                        w_mem_done_d = 1'b1;
                    end
                end else if (r_drain_cnt_q == '0) begin
                    w_state_d = S_INT_ACK;
                end else begin
                    w_drain_cnt_d = r_drain_cnt_q - C_CNT_ONE;
                end
            end
            S_INT_ACK: begin
                w_state_d = S_RUN;
            end
            default: begin
                w_state_d = S_RUN;
            end
        endcase
    end

    // Stall/flush/bubble decode from state and live hazard inputs
    always_comb begin
        w_stall_pc   = 1'b0;
        w_stall_f2d  = 1'b0;
        w_flush_f2d  = 1'b0;
        w_bubble_d2e = 1'b0;
        w_stall_d2e  = 1'b0;
        w_stall_e2m  = 1'b0;
        w_bubble_m2w = 1'b0;
        w_int_ack    = 1'b0;
        case (r_state_q)
            S_RUN: begin
                if (w_mem_trig) begin
                    w_stall_pc   = 1'b1;
                    w_stall_f2d  = 1'b1;
                    w_stall_d2e  = 1'b1;
                    w_stall_e2m  = 1'b1;
                    w_bubble_m2w = 1'b1;
                end else if (w_hazard) begin
                    // A taken branch is not flushed here; it re-resolves next cycle
                    w_stall_pc   = 1'b1;
                    w_stall_f2d  = 1'b1;
                    w_bubble_d2e = 1'b1;
                end else if (branchTaken) begin
                    w_flush_f2d = 1'b1;
                end
            end
            S_MEM_BUSY: begin
                w_stall_pc   = 1'b1;
                w_stall_f2d  = 1'b1;
                w_stall_d2e  = 1'b1;
                w_stall_e2m  = 1'b1;
                w_bubble_m2w = 1'b1;
            end
            S_INT_DRAIN: begin
                w_stall_pc  = 1'b1;
                w_flush_f2d = 1'b1;
                if (r_drain_frz_q || w_mem_trig) begin
                    w_stall_f2d  = 1'b1;
                    w_stall_d2e  = 1'b1;
                    w_stall_e2m  = 1'b1;
                    w_bubble_m2w = 1'b1;
                end
            end
            S_INT_ACK: begin
                w_int_ack = 1'b1;
            end
            default: begin
                w_int_ack = 1'b0;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held
    always_comb begin
        stallPC   = w_stall_pc   & rst;
        stallF2D  = w_stall_f2d  & rst;
        flushF2D  = w_flush_f2d  & rst;
        bubbleD2E = w_bubble_d2e & rst;
        stallD2E  = w_stall_d2e  & rst;
        stallE2M  = w_stall_e2m  & rst;
        bubbleM2W = w_bubble_m2w & rst;
        intAck    = w_int_ack    & rst;
        hduState  = rst ? r_state_q : 2'd0;
    end

endmodule
`default_nettype wire
